posit_div_operand_stage: RTL and testbench

POSIT_DIV_OPERAND_STAGE -- requirements
Module: posit_div_operand_stage

---
 rtl/posit_div_operand_stage.sv | 215 +++++++++++++++++++++
 tb/tb_posit_div_operand_stage.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/posit_div_operand_stage.sv
// Posit divider operand stage: two-stage valid/ready pipeline that decodes
// the dividend and divisor posits into hidden-one mantissas and a signed
// scale difference for the downstream mantissa divider.
//   S1: captures operand signs, absolute values and raw special flags.
//   S2: holds decoded fields; all data outputs come straight from S2.
// Optional feature macro: POSIT_DIV_SPECIAL_EN enables zero/NaR detection.
// ES must be at least 1.
module posit_div_operand_stage #(
   parameter  int SIZE    = 16,
   parameter  int ES      = 1,
   localparam int SCALE_W = $clog2(SIZE) + ES + 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [SIZE-1:0]            X1,
   input  logic [SIZE-1:0]            X2,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [SIZE-1:0]            x1_frac,
   output logic [SIZE-1:0]            x2_frac,
   output logic signed [SCALE_W-1:0]  scale_diff,
   output logic                       res_sign,
   output logic                       res_zero,
   output logic                       res_nar
);

   typedef struct packed {
      logic [SIZE-1:0]           frac;
      logic signed [SCALE_W-1:0] scale;
   } dec_t;

   // Regime/exponent/fraction decode of a non-negative posit magnitude.
   function automatic dec_t decode(input logic [SIZE-1:0] a);
      dec_t                      d;
      logic [SIZE-1:0]           body;
      logic [SIZE-1:0]           rem;
      logic [SIZE-1:0]           fr;
      logic [SCALE_W-1:0]        r;
      logic signed [SCALE_W-1:0] k;
      logic [ES-1:0]             e;
      logic                      rb;
      logic                      run;
      body = a << 1;                 // drop the sign position, regime at MSB
      rb   = body[SIZE-1];
      run  = 1'b1;
      r    = '0;
      for (int i = SIZE-1; i >= 1; i--) begin
         if (run && (body[i] == rb)) r = r + SCALE_W'(1);
         else                        run = 1'b0;
      end
      // Skip run plus terminator; shifting past the word leaves zeros, which
      // is exactly the "cut-off bits read as 0" rule for exponent and fraction.
      rem     = body << (r + SCALE_W'(1));
      e       = rem[SIZE-1 -: ES];
      fr      = rem << ES;
      k       = rb ? $signed(r - SCALE_W'(1)) : $signed(-r);
      d.frac  = {1'b1, {(SIZE-1){1'b0}}} | (fr >> 1);
      d.scale = (k <<< ES) + $signed({{(SCALE_W-ES){1'b0}}, e});
      return d;
   endfunction

   logic                     s1_valid_q, s1_valid_d;
   logic                     s1_sgn1_q,  s1_sgn1_d;
   logic                     s1_sgn2_q,  s1_sgn2_d;
   logic [SIZE-1:0]          s1_abs1_q,  s1_abs1_d;
   logic [SIZE-1:0]          s1_abs2_q,  s1_abs2_d;
   logic                     s2_valid_q, s2_valid_d;
   logic [SIZE-1:0]          s2_f1_q,    s2_f1_d;
   logic [SIZE-1:0]          s2_f2_q,    s2_f2_d;
   logic signed [SCALE_W-1:0] s2_sd_q,   s2_sd_d;
   logic                     s2_sgn_q,   s2_sgn_d;
   logic                     s1_adv;
   dec_t                     dec1, dec2;

`ifdef POSIT_DIV_SPECIAL_EN
   localparam logic [SIZE-1:0] NAR_PAT = {1'b1, {(SIZE-1){1'b0}}};
   logic s1_z1_q, s1_z1_d, s1_n1_q, s1_n1_d;
   logic s1_z2_q, s1_z2_d, s1_n2_q, s1_n2_d;
   logic s2_zero_q, s2_zero_d, s2_nar_q, s2_nar_d;
   logic sp_nar, sp_zero;
`endif

   // S1 moves on when S2 is free or S2 drains this cycle.
   assign s1_adv   = !s2_valid_q | out_ready;
   assign in_ready = !s1_valid_q | s1_adv;

   assign dec1 = decode(s1_abs1_q);
   assign dec2 = decode(s1_abs2_q);

`ifdef POSIT_DIV_SPECIAL_EN
   assign sp_nar  = s1_n1_q | s1_n2_q | s1_z2_q;
   assign sp_zero = s1_z1_q & !sp_nar;
`endif

   // S1 next state: capture signs, magnitudes and raw special patterns.
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_sgn1_d  = s1_sgn1_q;
      s1_sgn2_d  = s1_sgn2_q;
      s1_abs1_d  = s1_abs1_q;
      s1_abs2_d  = s1_abs2_q;
`ifdef POSIT_DIV_SPECIAL_EN
      s1_z1_d = s1_z1_q;
      s1_n1_d = s1_n1_q;
      s1_z2_d = s1_z2_q;
      s1_n2_d = s1_n2_q;
`endif
      if (in_ready) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_sgn1_d = X1[SIZE-1];
            s1_sgn2_d = X2[SIZE-1];
            s1_abs1_d = X1[SIZE-1] ? -X1 : X1;
            s1_abs2_d = X2[SIZE-1] ? -X2 : X2;
`ifdef POSIT_DIV_SPECIAL_EN
            s1_z1_d = (X1 == '0);
            s1_n1_d = (X1 == NAR_PAT);
            s1_z2_d = (X2 == '0);
            s1_n2_d = (X2 == NAR_PAT);
`endif
         end
      end
   end

   // S2 next state: decoded fields, cleared when a special result applies.
   always_comb begin
      s2_valid_d = s2_valid_q;
      s2_f1_d    = s2_f1_q;
      s2_f2_d    = s2_f2_q;
      s2_sd_d    = s2_sd_q;
      s2_sgn_d   = s2_sgn_q;
`ifdef POSIT_DIV_SPECIAL_EN
      s2_zero_d = s2_zero_q;
      s2_nar_d  = s2_nar_q;
`endif
      if (s1_adv) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_f1_d  = dec1.frac;
            s2_f2_d  = dec2.frac;
            s2_sd_d  = dec1.scale - dec2.scale;
            s2_sgn_d = s1_sgn1_q ^ s1_sgn2_q;
`ifdef POSIT_DIV_SPECIAL_EN
            s2_zero_d = sp_zero;
            s2_nar_d  = sp_nar;
            if (sp_zero | sp_nar) begin
               s2_f1_d  = '0;
               s2_f2_d  = '0;
               s2_sd_d  = '0;
               s2_sgn_d = 1'b0;
            end
`endif
         end
      end
   end

   // Pipeline registers with synchronous clear; reset drops in-flight pairs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_sgn1_q  <= 1'b0;
         s1_sgn2_q  <= 1'b0;
         s1_abs1_q  <= '0;
         s1_abs2_q  <= '0;
         s2_valid_q <= 1'b0;
         s2_f1_q    <= '0;
         s2_f2_q    <= '0;
         s2_sd_q    <= '0;
         s2_sgn_q   <= 1'b0;
`ifdef POSIT_DIV_SPECIAL_EN
         s1_z1_q   <= 1'b0;
         s1_n1_q   <= 1'b0;
         s1_z2_q   <= 1'b0;
         s1_n2_q   <= 1'b0;
         s2_zero_q <= 1'b0;
         s2_nar_q  <= 1'b0;
`endif
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_sgn1_q  <= s1_sgn1_d;
         s1_sgn2_q  <= s1_sgn2_d;
         s1_abs1_q  <= s1_abs1_d;
         s1_abs2_q  <= s1_abs2_d;
         s2_valid_q <= s2_valid_d;
         s2_f1_q    <= s2_f1_d;
         s2_f2_q    <= s2_f2_d;
         s2_sd_q    <= s2_sd_d;
         s2_sgn_q   <= s2_sgn_d;
`ifdef POSIT_DIV_SPECIAL_EN
         s1_z1_q   <= s1_z1_d;
         s1_n1_q   <= s1_n1_d;
         s1_z2_q   <= s1_z2_d;
         s1_n2_q   <= s1_n2_d;
         s2_zero_q <= s2_zero_d;
         s2_nar_q  <= s2_nar_d;
`endif
      end
   end

   assign out_valid  = s2_valid_q;
   assign x1_frac    = s2_f1_q;
   assign x2_frac    = s2_f2_q;
   assign scale_diff = s2_sd_q;
   assign res_sign   = s2_sgn_q;
`ifdef POSIT_DIV_SPECIAL_EN
   assign res_zero = s2_zero_q;
   assign res_nar  = s2_nar_q;
`else
   assign res_zero = 1'b0;
   assign res_nar  = 1'b0;
`endif

endmodule

// File: tb/tb_posit_div_operand_stage.sv
// Self-checking bench for posit_div_operand_stage: directed steps plus a
// randomized phase, scoreboarded against a bit-walking posit decode model.
module tb_posit_div_operand_stage;
   localparam int SZ = 16;
   localparam int ES = 1;
   localparam int SW = $clog2(SZ) + ES + 2;

   typedef struct packed {
      logic [SZ-1:0] f1;
      logic [SZ-1:0] f2;
      logic [SW-1:0] sd;
      logic          sg;
      logic          z;
      logic          n;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n, in_valid, in_ready, out_valid, out_ready;
   logic [SZ-1:0] X1, X2, x1_frac, x2_frac;
   logic [SW-1:0] scale_diff;
   logic          res_sign, res_zero, res_nar;

   exp_t q[$];
   int   acc_q[$];
   int   cyc_n = 0;
   int   nassert = 0;
   int   nfail = 0;
   bit   lat_mode = 0;
   bit   held = 0;
   exp_t held_v;

   posit_div_operand_stage #(.SIZE(SZ), .ES(ES)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .X1(X1), .X2(X2), .out_valid(out_valid), .out_ready(out_ready),
      .x1_frac(x1_frac), .x2_frac(x2_frac), .scale_diff(scale_diff),
      .res_sign(res_sign), .res_zero(res_zero), .res_nar(res_nar)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc_n <= cyc_n + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      nassert++;
      assert (obs === expv) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Walk the posit bits one position at a time.
   function automatic void pdecode(input logic [SZ-1:0] x, output logic [SZ-1:0] frac,
                                   output int scale);
      logic [SZ-1:0] a;
      logic          rb;
      int            pos, r, k, e, n;
      a   = x[SZ-1] ? (~x + 1'b1) : x;
      pos = SZ - 2;
      rb  = a[pos];
      r   = 0;
      while (pos >= 0 && a[pos] == rb) begin r++; pos--; end
      k = rb ? r - 1 : -r;
      pos--;
      e = 0;
      for (int j = 0; j < ES; j++) begin
         e = e * 2 + ((pos >= 0) ? int'(a[pos]) : 0);
         pos--;
      end
      n     = (pos >= 0) ? pos + 1 : 0;
      frac  = SZ'(32'd1 << (SZ - 1)) | SZ'((32'(a) & ((32'd1 << n) - 1)) << (SZ - 1 - n));
      scale = k * (1 << ES) + e;
   endfunction

   function automatic exp_t model(input logic [SZ-1:0] a1, input logic [SZ-1:0] a2);
      exp_t          r;
      logic [SZ-1:0] f1, f2;
      int            s1, s2;
      pdecode(a1, f1, s1);
      pdecode(a2, f2, s2);
      r.f1 = f1;
      r.f2 = f2;
      r.sd = SW'(s1 - s2);
      r.sg = a1[SZ-1] ^ a2[SZ-1];
      r.z  = 1'b0;
      r.n  = 1'b0;
`ifdef POSIT_DIV_SPECIAL_EN
      begin
         logic [SZ-1:0] nar_p;
         nar_p = {1'b1, {(SZ-1){1'b0}}};
         r.n = (a1 == nar_p) || (a2 == nar_p) || (a2 == '0);
         r.z = (a1 == '0) && !r.n;
         if (r.n || r.z) begin r.f1 = '0; r.f2 = '0; r.sd = '0; r.sg = 1'b0; end
      end
`endif
      return r;
   endfunction

   // Scoreboard, evaluated on the falling edge (state before the next rise).
   task automatic sb();
      exp_t o, e;
      int   a;
      o = {x1_frac, x2_frac, scale_diff, res_sign, res_zero, res_nar};
      if (!rst_n) begin
         q.delete(); acc_q.delete(); held = 0;
      end else begin
         if (held) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_data", 64'(o), 64'(held_v));
         end
         held = 0;
         if (out_valid) begin
            if (q.size() == 0) chk("spurious_out", 64'(out_valid), 64'd0);
            else if (out_ready) begin
               e = q.pop_front();
               a = acc_q.pop_front();
               chk("out_data", 64'(o), 64'(e));
               if (lat_mode) chk("latency", 64'(cyc_n - a), 64'd2);
            end else begin
               held = 1; held_v = o;
            end
         end
         if (in_valid && in_ready) begin
            q.push_back(model(X1, X2));
            acc_q.push_back(cyc_n);
         end
      end
   endtask

   task automatic cyc();
      @(negedge clk);
      sb();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [SZ-1:0] rnd_posit();
      int sel;
      sel = $urandom_range(0, 15);
      if (sel == 0) return '0;
      if (sel == 1) return {1'b1, {(SZ-1){1'b0}}};
      return SZ'($urandom);
   endfunction

   initial begin
      logic exp_nar, exp_zero;
`ifdef POSIT_DIV_SPECIAL_EN
      exp_nar = 1'b1; exp_zero = 1'b1;
`else
      exp_nar = 1'b0; exp_zero = 1'b0;
`endif
      // Reset state
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; X1 = '0; X2 = '0;
      cyc(); cyc();
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_x1_frac", 64'(x1_frac), 64'd0);
      chk("rst_x2_frac", 64'(x2_frac), 64'd0);
      chk("rst_scale", 64'(scale_diff), 64'd0);
      chk("rst_flags", 64'({res_sign, res_zero, res_nar}), 64'd0);
      rst_n = 1'b1;
      cyc();
      chk("rst_in_ready", 64'(in_ready), 64'd1);

      // Known-answer decode, two-cycle latency
      lat_mode = 1; out_ready = 1'b1;
      X1 = 16'h4800; X2 = 16'h5000; in_valid = 1'b1;
      cyc(); in_valid = 1'b0; cyc();
      chk("kat1_valid", 64'(out_valid), 64'd1);
      chk("kat1_x1f", 64'(x1_frac), 64'hC000);
      chk("kat1_x2f", 64'(x2_frac), 64'h8000);
      chk("kat1_sd", 64'(scale_diff), 64'({SW{1'b1}}));
      chk("kat1_sign", 64'(res_sign), 64'd0);
      cyc();
      X1 = 16'hC000; X2 = 16'h4000; in_valid = 1'b1;
      cyc(); in_valid = 1'b0; cyc();
      chk("kat2_x1f", 64'(x1_frac), 64'h8000);
      chk("kat2_x2f", 64'(x2_frac), 64'h8000);
      chk("kat2_sd", 64'(scale_diff), 64'd0);
      chk("kat2_sign", 64'(res_sign), 64'd1);
      cyc();

      // Special patterns
      X1 = 16'h4000; X2 = 16'h0000; in_valid = 1'b1;
      cyc(); in_valid = 1'b0; cyc();
      chk("sp_div0_nar", 64'(res_nar), 64'(exp_nar));
      chk("sp_div0_zero", 64'(res_zero), 64'd0);
      cyc();
      X1 = 16'h0000; X2 = 16'h4000; in_valid = 1'b1;
      cyc(); in_valid = 1'b0; cyc();
      chk("sp_zero", 64'(res_zero), 64'(exp_zero));
      chk("sp_zero_nar", 64'(res_nar), 64'd0);
      cyc();

      // Back-to-back throughput with out_ready held high
      for (int i = 0; i < 6; i++) begin
         X1 = rnd_posit(); X2 = rnd_posit(); in_valid = 1'b1;
         chk("tput_in_ready", 64'(in_ready), 64'd1);
         cyc();
      end
      in_valid = 1'b0;
      cyc(); cyc();
      lat_mode = 0;

      // Backpressure: fill both stages, third pair refused
      out_ready = 1'b0;
      X1 = SZ'($urandom); X2 = SZ'($urandom); in_valid = 1'b1;
      chk("bp_acc_a", 64'(in_ready), 64'd1);
      cyc();
      X1 = SZ'($urandom); X2 = SZ'($urandom);
      chk("bp_acc_b", 64'(in_ready), 64'd1);
      cyc();
      X1 = SZ'($urandom); X2 = SZ'($urandom);
      chk("bp_full_in_ready", 64'(in_ready), 64'd0);
      cyc(); cyc();
      chk("bp_still_full", 64'(in_ready), 64'd0);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      out_ready = 1'b1;
      #1;
      chk("bp_release_in_ready", 64'(in_ready), 64'd1);
      cyc();
      in_valid = 1'b0;
      repeat (4) cyc();

      // Reset with both stages valid discards the pairs
      out_ready = 1'b0;
      X1 = SZ'($urandom); X2 = SZ'($urandom); in_valid = 1'b1;
      cyc();
      X1 = SZ'($urandom); X2 = SZ'($urandom);
      cyc();
      in_valid = 1'b0;
      chk("mid_full", 64'({out_valid, in_ready}), 64'b10);
      rst_n = 1'b0;
      cyc();
      chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_data", 64'({x1_frac, x2_frac, scale_diff, res_sign, res_zero, res_nar}), 64'd0);
      rst_n = 1'b1; out_ready = 1'b1;
      #1;
      chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
      repeat (4) cyc();

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         X1 = rnd_posit(); X2 = rnd_posit();
         cyc();
      end

      // Drain
      in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 20 && q.size() > 0; i++) cyc();
      chk("drain_empty", 64'(q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
      $finish;
   end
endmodule
